// File: rtl/ctrl_weight_loader.sv
// ctrl_weight_loader
// Accepts one packed weight matrix over a valid/ready handshake, holds it in a
// single buffer, then streams it one PE row per cycle (highest row first) into
// the systolic array's weight-preload chain. A new matrix may be accepted on
// the cycle the last row leaves, so consecutive matrices stream without gaps.
module ctrl_weight_loader #(
  parameter  int WEIGHT_BW   = 8,
  parameter  int NUM_PE_ROWS = 8,
  parameter  int MATRIX_SIZE = 8,
  localparam int ROW_W       = WEIGHT_BW * MATRIX_SIZE,
  localparam int MAT_W       = ROW_W * NUM_PE_ROWS,
  localparam int IDX_W       = (NUM_PE_ROWS > 1) ? $clog2(NUM_PE_ROWS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [MAT_W-1:0] in_matrix,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ROW_W-1:0] row_data,
  output logic [IDX_W-1:0] row_idx,
  output logic             row_valid,
  input  logic             row_ready,
  output logic             done,
  output logic             busy
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE_ROWS - 1);

  logic [0:0]       state;
  logic [MAT_W-1:0] buffer;
  logic             row_xfer;
  logic             last_xfer;
  logic             accept;
  logic [IDX_W-1:0] nxt_idx;

  // Outputs that follow directly from the registered state.
  assign row_valid = (state == S_DRAIN);
  assign busy      = (state == S_DRAIN);

  // Ready in idle, or while the last row is leaving so the next matrix can
  // follow it with no bubble.
  assign in_ready = (state == S_IDLE) ||
                    ((state == S_DRAIN) && (row_idx == '0) && row_ready);

  // Handshake qualifiers and the index of the row presented after a transfer.
  always_comb begin
    row_xfer  = row_valid && row_ready;
    last_xfer = row_xfer && (row_idx == '0);
    accept    = in_valid && in_ready;
    nxt_idx   = row_idx - 1'b1;
  end

  // Matrix capture, row sequencing and completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      buffer   <= '0;
      row_data <= '0;
      row_idx  <= '0;
      done     <= 1'b0;
    end else begin
      done <= last_xfer;
      case (state)
        S_IDLE: begin
          if (accept) begin
            buffer   <= in_matrix;
            row_data <= in_matrix[MAT_W-1 -: ROW_W];
            row_idx  <= LAST_IDX;
            state    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (last_xfer) begin
            if (accept) begin
              // Next matrix takes over the buffer on the same edge.
              buffer   <= in_matrix;
              row_data <= in_matrix[MAT_W-1 -: ROW_W];
              row_idx  <= LAST_IDX;
            end else begin
              row_data <= '0;
              state    <= S_IDLE;
            end
          end else if (row_xfer) begin
            row_idx  <= nxt_idx;
            row_data <= buffer[int'(nxt_idx) * ROW_W +: ROW_W];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_weight_loader.sv
// Testbench for ctrl_weight_loader: scenario tasks plus a scoreboard monitor
// that predicts every emitted row and every done pulse.
module tb_ctrl_weight_loader;

  localparam int WB  = 8;
  localparam int NR  = 8;
  localparam int MS  = 8;
  localparam int RW  = WB * MS;
  localparam int MW  = RW * NR;
  localparam int IW  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [MW-1:0] in_matrix = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [RW-1:0] row_data;
  logic [IW-1:0] row_idx;
  logic          row_valid;
  logic          row_ready = 1'b0;
  logic          done;
  logic          busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [IW-1:0] idx;
    logic [RW-1:0] data;
  } row_t;

  row_t exp_q[$];
  bit   mon_en   = 1'b0;
  bit   exp_done = 1'b0;

  ctrl_weight_loader #(
    .WEIGHT_BW  (WB),
    .NUM_PE_ROWS(NR),
    .MATRIX_SIZE(MS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_matrix(in_matrix),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .row_data (row_data),
    .row_idx  (row_idx),
    .row_valid(row_valid),
    .row_ready(row_ready),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Scoreboard: inputs are stable at the falling edge, so any handshake seen
  // here completes on the next rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      bit   nxt_done;
      row_t e;
      nxt_done = 1'b0;
      n_chk++;
      if (done !== exp_done) begin
        n_fail++;
        $display("FAIL done_pulse t=%0t got %b expected %b", $time, done, exp_done);
      end
      if (row_valid === 1'b1 && row_ready === 1'b1) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_row t=%0t got idx %0d data %h expected no row", $time, row_idx, row_data);
        end else begin
          e = exp_q.pop_front();
          if (row_idx !== e.idx || row_data !== e.data) begin
            n_fail++;
            $display("FAIL row_order t=%0t got idx %0d data %h expected idx %0d data %h",
                     $time, row_idx, row_data, e.idx, e.data);
          end
          if (e.idx == 0) nxt_done = 1'b1;
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        for (int r = NR - 1; r >= 0; r--) begin
          row_t n;
          n.idx  = IW'(r);
          n.data = in_matrix[r*RW +: RW];
          exp_q.push_back(n);
        end
      end
      exp_done = nxt_done;
    end
  end

  // Stimulus changes one time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MW-1:0] rows_plus_one();
    logic [MW-1:0] m;
    m = '0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < MS; c++)
        m[(r*MS + c)*WB +: WB] = WB'(r + 1);
    return m;
  endfunction

  function automatic logic [MW-1:0] rand_matrix();
    logic [MW-1:0] m;
    for (int i = 0; i < MW / 32; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    row_ready = 1'b1;
    in_valid  = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      #1;
      if (!row_valid && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_drain_timeout got %0d rows pending expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    repeat (3) tick();
    #1;
    n_chk++;
    if ({row_valid, row_data, row_idx, done, busy, in_ready} !== {1'b0, {RW{1'b0}}, {IW{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs got rv=%b data=%h idx=%0d done=%b busy=%b in_ready=%b expected all 0, in_ready=1",
               row_valid, row_data, row_idx, done, busy, in_ready);
    end
    tick();
    reset    = 1'b0;
    exp_done = 1'b0;
    exp_q.delete();
    mon_en   = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      #1;
      n_chk++;
      if (row_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_quiet cycle %0d got rv=%b in_ready=%b busy=%b expected 0,1,0",
                 k, row_valid, in_ready, busy);
      end
    end
  endtask

  task automatic test_single_matrix();
    int done_cnt;
    done_cnt  = 0;
    row_ready = 1'b1;
    in_matrix = rows_plus_one();
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (done) done_cnt++;
      n_chk++;
      if (k < 8) begin
        if (row_valid !== 1'b1 || row_idx !== IW'(7 - k) || row_data !== {MS{WB'(8 - k)}} ||
            in_ready !== (k == 7)) begin
          n_fail++;
          $display("FAIL single_row k=%0d got rv=%b idx=%0d data=%h in_ready=%b expected rv=1 idx=%0d data=%h in_ready=%b",
                   k, row_valid, row_idx, row_data, in_ready, 7 - k, {MS{WB'(8 - k)}}, (k == 7));
        end
      end else begin
        if (row_valid !== 1'b0 || done !== (k == 8)) begin
          n_fail++;
          $display("FAIL single_tail k=%0d got rv=%b done=%b expected rv=0 done=%b", k, row_valid, done, (k == 8));
        end
      end
      tick();
    end
    n_chk++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL single_done_count got %0d expected 1", done_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] p_data;
    logic [IW-1:0] p_idx;
    bit            p_stall;
    p_stall   = 1'b0;
    p_data    = '0;
    p_idx     = '0;
    row_ready = 1'b0;
    in_matrix = rand_matrix();
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      row_ready = (k % 4 == 0) || (k % 4 == 3);
      in_matrix = rand_matrix();
      #1;
      if (p_stall) begin
        n_chk++;
        if (row_valid !== 1'b1 || row_data !== p_data || row_idx !== p_idx) begin
          n_fail++;
          $display("FAIL bp_hold k=%0d got rv=%b idx=%0d data=%h expected rv=1 idx=%0d data=%h",
                   k, row_valid, row_idx, row_data, p_idx, p_data);
        end
      end
      p_stall = row_valid && !row_ready;
      p_data  = row_data;
      p_idx   = row_idx;
      tick();
    end
    wait_drain("bp");
  endtask

  task automatic test_back_to_back();
    logic [19:0] rv_trace;
    int          done_cnt;
    bit          drop;
    logic [MW-1:0] mb;
    rv_trace  = '0;
    done_cnt  = 0;
    drop      = 1'b0;
    mb        = rand_matrix();
    row_ready = 1'b1;
    in_matrix = rand_matrix();
    in_valid  = 1'b1;
    tick();
    in_matrix = mb;
    for (int k = 0; k < 20; k++) begin
      #1;
      rv_trace[k] = row_valid;
      if (done) done_cnt++;
      drop = in_valid && in_ready;
      tick();
      if (drop) in_valid = 1'b0;
    end
    n_chk++;
    if (rv_trace !== 20'h0FFFF) begin
      n_fail++;
      $display("FAIL b2b_contiguous got %h expected %h", rv_trace, 20'h0FFFF);
    end
    n_chk++;
    if (done_cnt != 2) begin
      n_fail++;
      $display("FAIL b2b_done_count got %0d expected 2", done_cnt);
    end
    wait_drain("b2b");
  endtask

  task automatic test_reset_mid_drain();
    bit hit;
    hit       = 1'b0;
    row_ready = 1'b1;
    in_matrix = rand_matrix();
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (row_valid && row_idx == 3'd4) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL rst_mid_reach got idx %0d expected 4", row_idx);
    end
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    n_chk++;
    if ({row_valid, row_data, row_idx, done, busy, in_ready} !== {1'b0, {RW{1'b0}}, {IW{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_mid_async got rv=%b data=%h idx=%0d done=%b busy=%b in_ready=%b expected all 0, in_ready=1",
               row_valid, row_data, row_idx, done, busy, in_ready);
    end
    tick();
    tick();
    reset    = 1'b0;
    exp_q.delete();
    exp_done = 1'b0;
    mon_en   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      #1;
      n_chk++;
      if (row_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_mid_stale k=%0d got rv=%b in_ready=%b expected 0,1", k, row_valid, in_ready);
      end
    end
  endtask

  task automatic test_input_ignored();
    row_ready = 1'b1;
    in_matrix = rand_matrix();
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_matrix = rand_matrix();
      tick();
    end
    wait_drain("ignore");
  endtask

  task automatic test_random_traffic();
    for (int k = 0; k < 300; k++) begin
      row_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_matrix = rand_matrix();
      tick();
    end
    wait_drain("random");
  endtask

  initial begin
    test_reset();
    test_single_matrix();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_drain();
    test_input_ignored();
    test_random_traffic();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue got %0d rows pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_weight_loader.md
Name: ctrl_weight_loader

Overview:
Consumer for the packed weight-matrix bus that the random/weight generator drives. It accepts one flat matrix of NUM_PE_ROWS x MATRIX_SIZE weights over a valid/ready handshake and holds it in a single matrix buffer. It then streams the matrix one PE row per cycle, highest row first, into the systolic array's weight-preload shift chain under a second valid/ready handshake. It pulses `done` when the last row of each matrix is transferred.

Parameters:
WEIGHT_BW, 8, bits per weight
NUM_PE_ROWS, 8, rows per matrix and rows emitted per matrix
MATRIX_SIZE, 8, weights per row
ROW_W, derived = WEIGHT_BW*MATRIX_SIZE; not overridable

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_matrix  in  WEIGHT_BW*NUM_PE_ROWS*MATRIX_SIZE  packed matrix; row r = bits [(r+1)*ROW_W-1 : r*ROW_W]
in_valid  in  1  in_matrix valid
in_ready  out  1  loader can accept a matrix
row_data  out  ROW_W  current row; weight c = bits [(c+1)*WEIGHT_BW-1 : c*WEIGHT_BW]
row_idx  out  clog2(NUM_PE_ROWS), min 1  index of the row on row_data
row_valid  out  1  row_data/row_idx valid
row_ready  in  1  array accepts row
done  out  1  one-cycle pulse after the last row (idx 0) transfers
busy  out  1  high while the buffer holds an undrained matrix

Behaviour:
- Reset (async, active-high): state=IDLE, buffer=0, row_data=0, row_idx=0, row_valid=0, in_ready=1, done=0, busy=0. Asserting reset mid-drain discards the matrix immediately. No partial rows are emitted after reset releases.
- FSM: IDLE, DRAIN.
- IDLE: in_ready=1 and row_valid=0. When in_valid&in_ready, latch in_matrix into the buffer, set row_idx=NUM_PE_ROWS-1, and go to DRAIN.
- DRAIN: row_valid=1. row_data = buffer row[row_idx], registered and valid in the same cycle as row_valid. busy=1.
- A row transfers on row_valid&row_ready.
- On a transfer with row_idx>0: decrement row_idx; the next row is presented the following cycle.
- If row_ready is low, row_data and row_idx hold stable.
- Last-row transfer (row_idx==0): done=1 on the next cycle for exactly one cycle.
- in_ready is combinational: high in IDLE, or in DRAIN when row_idx==0 & row_ready. This lets back-to-back matrices stream with zero bubbles.
- If in_valid is high on that last-row cycle: latch the new matrix, stay in DRAIN, set row_idx=NUM_PE_ROWS-1. done still pulses for the finished matrix.
- If in_valid is low on that last-row cycle: go to IDLE and drop row_valid.
- Latency:
  - in_valid accepted at cycle t gives the first row_valid at t+1.
  - A full matrix drains in NUM_PE_ROWS cycles with row_ready held high.
- in_matrix is sampled only on handshake. Changes while in_ready=0 are ignored.
- row_valid, once asserted, is never withdrawn before its transfer, except by reset.
- NUM_PE_ROWS=1: every transfer is the last row; done pulses per matrix.

Test Plan:
- Reset then idle -> all outputs 0 except in_ready=1; no row_valid for 20 cycles with in_valid=0.
- One matrix with row r filled with byte value r+1, row_ready=1 -> rows emitted on 8 consecutive cycles.
  - row_idx sequence 7..0; row_data 0x0808..08 down to 0x0101..01.
  - done pulses once, one cycle after idx 0.
  - in_ready low during idx 7..1.
- Backpressure: toggle row_ready 1,0,0,1,... during a drain -> row_data/row_idx stable while row_ready=0; each row emitted exactly once, in order.
- Back-to-back matrices A then B with in_valid held high and row_ready=1 -> 16 contiguous row_valid cycles.
  - B's row 7 follows A's row 0 with no gap.
  - done pulses after A and after B.
- Reset asserted while row_idx=4 -> outputs zero immediately (async). After release, in_ready=1 and no stale rows appear.
- in_matrix changed while in_ready=0 -> emitted rows match the originally latched matrix.
